// File: rtl/literal_stream_ctrl.sv
// Streams literals from a synchronous literal memory into a pure_literals block,
// tags each with its reduced-formula flag and captures the resulting pure mask.
module literal_stream_ctrl #(
   parameter int WIDTH    = 4,
   parameter int OUT_SIZE = 16,
   parameter int ADDR_W   = 5,
   parameter int TIMEOUT  = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W:0]     num_lits,
   input  logic [OUT_SIZE-1:0] assigned,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_rd,
   input  logic [WIDTH:0]      mem_rdata,
   output logic                pl_reset,
   output logic [WIDTH:0]      pl_literal_in,
   output logic                pl_reduced_form,
   output logic                pl_inputs_over,
   input  logic                pl_valid_out,
   input  logic [OUT_SIZE-1:0] pl_pure_literals,
   output logic                busy,
   output logic                done,
   output logic [OUT_SIZE-1:0] pure_mask,
   output logic                timeout_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int NVAR  = 1 << WIDTH;
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, OVER, FINISH} state_t;

   state_t            state;
   logic [ADDR_W:0]   lits;
   logic [NVAR-1:0]   assigned_lat;
   logic [CNT_W-1:0]  cnt;
   logic              clear_pulse;
   logic              lit_valid;
   logic [WIDTH:0]    mag;
   logic [NVAR-1:0]   hit;
   logic [ADDR_W:0]   lits_clamped;

   assign lits_clamped = (num_lits > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_lits;

   // The memory returns data one cycle after the read, so the literal is
   // forwarded straight from mem_rdata while the delayed read-valid flag is set.
   assign pl_literal_in = lit_valid ? mem_rdata : '0;
   assign mag           = mem_rdata[WIDTH] ? (~mem_rdata + 1'b1) : mem_rdata;

   // One-hot variable match; the most-negative literal has magnitude 2^WIDTH.
   generate
      for (genvar gi = 0; gi < NVAR; gi++) begin : g_hit
         assign hit[gi] = assigned_lat[gi] && (mag == (WIDTH+1)'(gi + 1));
      end
   endgenerate

   assign pl_reduced_form = lit_valid && (mag != '0) && !(|hit);
   assign pl_reset        = clear_pulse | reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         lits           <= '0;
         assigned_lat   <= '0;
         cnt            <= '0;
         clear_pulse    <= 1'b0;
         lit_valid      <= 1'b0;
         mem_addr       <= '0;
         mem_rd         <= 1'b0;
         pl_inputs_over <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pure_mask      <= '0;
         timeout_err    <= 1'b0;
      end else begin
         done        <= 1'b0;
         clear_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= CLEAR;
                  busy         <= 1'b1;
                  clear_pulse  <= 1'b1;
                  lits         <= lits_clamped;
                  assigned_lat <= assigned[NVAR-1:0];
                  timeout_err  <= 1'b0;
               end
            end
            CLEAR: begin
               cnt <= '0;
               if (lits != '0) begin
                  state    <= STREAM;
                  mem_rd   <= 1'b1;
                  mem_addr <= '0;
               end else begin
                  state          <= OVER;
                  pl_inputs_over <= 1'b1;
               end
            end
            STREAM: begin
               lit_valid <= 1'b1;
               if ({1'b0, mem_addr} == lits - 1'b1) begin
                  state    <= DRAIN;
                  mem_rd   <= 1'b0;
                  mem_addr <= '0;
               end else begin
                  mem_addr <= mem_addr + 1'b1;
               end
            end
            DRAIN: begin
               state          <= OVER;
               lit_valid      <= 1'b0;
               pl_inputs_over <= 1'b1;
               cnt            <= '0;
            end
            OVER: begin
               // A result arriving on the timeout cycle still counts.
               if (pl_valid_out) begin
                  pure_mask      <= pl_pure_literals;
                  state          <= FINISH;
                  done           <= 1'b1;
                  pl_inputs_over <= 1'b0;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  pure_mask      <= '0;
                  timeout_err    <= 1'b1;
                  state          <= FINISH;
                  done           <= 1'b1;
                  pl_inputs_over <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
